// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stage stall/flush controls,
// Execute-stage forwarding selects, and a small FSM sequencing data-memory
// wait states and multi-cycle mul/div operations.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [4:0]       i_Rs1D,
  input  logic [4:0]       i_Rs2D,
  input  logic [4:0]       i_Rs1E,
  input  logic [4:0]       i_Rs2E,
  input  logic [4:0]       i_RdE,
  input  logic [4:0]       i_RdM,
  input  logic [4:0]       i_RdW,
  input  logic             i_RegWriteM,
  input  logic             i_RegWriteW,
  input  logic             i_LoadE,
  input  logic             i_PCSrcE,
  input  logic             i_MemReqM,
  input  logic             i_MemReadyM,
  input  logic             i_MulDivStartE,
  input  logic             i_MulDivDone,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_StallE,
  output logic             o_StallM,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_FlushM,
  output logic             o_FlushW,
  output logic [1:0]       o_ForwardAE,
  output logic [1:0]       o_ForwardBE,
  output logic             o_MemFault,
  output logic [1:0]       o_State,
  output logic [CNT_W-1:0] o_StallCount
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StMdBusy  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_fault_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic timeout, mem_wait, md_wait, lw_stall;

  // Forward select for one Execute source: M has priority over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == rs)) begin
      return 2'b10;
    end else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Hazard conditions from current state and inputs.
  always_comb begin
    timeout  = (state_q == StMemWait) && (wait_q == WaitW'(MEM_TIMEOUT - 1));
    mem_wait = ((state_q == StRun) && i_MemReqM && !i_MemReadyM) ||
               ((state_q == StMemWait) && !i_MemReadyM && !timeout);
    md_wait  = !mem_wait &&
               (((state_q == StRun) && i_MulDivStartE && !i_MulDivDone) ||
                ((state_q == StMdBusy) && !i_MulDivDone));
    lw_stall = i_LoadE && (i_RdE != 5'd0) && ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
  end

  // Stall/flush/forward outputs; reset forces bubbles into every stage.
  always_comb begin
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_StallE    = 1'b0;
    o_StallM    = 1'b0;
    o_FlushD    = 1'b0;
    o_FlushE    = 1'b0;
    o_FlushM    = 1'b0;
    o_FlushW    = 1'b0;
    o_ForwardAE = 2'b00;
    o_ForwardBE = 2'b00;
    if (i_Reset) begin
      o_FlushD = 1'b1;
      o_FlushE = 1'b1;
      o_FlushM = 1'b1;
      o_FlushW = 1'b1;
    end else begin
      o_ForwardAE = fwd_sel(i_Rs1E);
      o_ForwardBE = fwd_sel(i_Rs2E);
      if (mem_wait) begin
        // Freeze F..M; the held branch in E is acted on once memory completes.
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_StallM = 1'b1;
        o_FlushW = 1'b1;
      end else if (md_wait) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_FlushM = 1'b1;
      end else if (i_PCSrcE) begin
        o_FlushD = 1'b1;
        o_FlushE = 1'b1;
      end else if (lw_stall) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_FlushE = 1'b1;
      end
    end
  end

  // Next-state, wait counter and stall performance counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        if (i_MemReqM && !i_MemReadyM) begin
          state_d = StMemWait;
          wait_d  = '0;
        end else if (i_MulDivStartE && !i_MulDivDone) begin
          state_d = StMdBusy;
        end
      end
      StMemWait: begin
        if (i_MemReadyM || timeout) begin
          state_d = StRun;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StMdBusy: begin
        if (i_MulDivDone) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (o_StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= StRun;
      wait_q      <= '0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_fault_q <= timeout;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_MemFault   = mem_fault_q;
  assign o_State      = state_q;
  assign o_StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle vectors in RUN
// plus hand-written sequences for memory wait, timeout, mul/div and reset.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MemTimeout = 16;
  localparam int unsigned CntW       = 5;

  logic clk, rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic rwm, rww, loade, pcsrc, memreq, memready, mdstart, mddone;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a, fwd_b, state;
  logic fault;
  logic [CntW-1:0] stall_cnt;
  logic [11:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Rs1D        (rs1d),
    .i_Rs2D        (rs2d),
    .i_Rs1E        (rs1e),
    .i_Rs2E        (rs2e),
    .i_RdE         (rde),
    .i_RdM         (rdm),
    .i_RdW         (rdw),
    .i_RegWriteM   (rwm),
    .i_RegWriteW   (rww),
    .i_LoadE       (loade),
    .i_PCSrcE      (pcsrc),
    .i_MemReqM     (memreq),
    .i_MemReadyM   (memready),
    .i_MulDivStartE(mdstart),
    .i_MulDivDone  (mddone),
    .o_StallF      (stall_f),
    .o_StallD      (stall_d),
    .o_StallE      (stall_e),
    .o_StallM      (stall_m),
    .o_FlushD      (flush_d),
    .o_FlushE      (flush_e),
    .o_FlushM      (flush_m),
    .o_FlushW      (flush_w),
    .o_ForwardAE   (fwd_a),
    .o_ForwardBE   (fwd_b),
    .o_MemFault    (fault),
    .o_State       (state),
    .o_StallCount  (stall_cnt)
  );

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW, FwdA, FwdB}
  assign outs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                 fwd_a, fwd_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwm, rww, loade, pcsrc;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int a1d, input int a2d, input int a1e, input int a2e,
                              input int ade, input int adm, input int adw, input int wm,
                              input int ww, input int ld, input int pc, input logic [11:0] e);
    vec_t v;
    v.rs1d  = 5'(a1d);
    v.rs2d  = 5'(a2d);
    v.rs1e  = 5'(a1e);
    v.rs2e  = 5'(a2e);
    v.rde   = 5'(ade);
    v.rdm   = 5'(adm);
    v.rdw   = 5'(adw);
    v.rwm   = 1'(wm);
    v.rww   = 1'(ww);
    v.loade = 1'(ld);
    v.pcsrc = 1'(pc);
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    rwm = 0; rww = 0; loade = 0; pcsrc = 0; memreq = 0; memready = 0;
    mdstart = 0; mddone = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a request whose ready never comes; count stall cycles and early faults.
  task automatic run_timeout(output int n_stall, output int n_fault);
    n_stall = 0;
    n_fault = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      memreq   = (c < 16);
      memready = 1'b0;
      #1;
      if (stall_f) n_stall++;
      if (fault) n_fault++;
    end
  endtask

  initial begin
    int ns, nf;
    rst = 1'b1;
    clear_inputs();
    #2;
    check("reset_outs", 32'(outs), 32'b0000_1111_0000);
    check("reset_state", 32'(state), 0);
    check("reset_cnt", 32'(stall_cnt), 0);
    check("reset_fault", 32'(fault), 0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 12'b0000_0000_10_00);
    vecs[1]  = mk(0, 0, 5, 5, 0, 5, 5, 0, 1, 0, 0, 12'b0000_0000_01_01);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12'b0000_0000_00_00);
    vecs[3]  = mk(0, 0, 6, 5, 0, 5, 6, 1, 1, 0, 0, 12'b0000_0000_01_10);
    vecs[4]  = mk(0, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 12'b1100_0100_00_00);
    vecs[5]  = mk(0, 3, 0, 0, 3, 0, 0, 0, 0, 1, 1, 12'b0000_1100_00_00);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12'b0000_0000_00_00);
    vecs[7]  = mk(4, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 12'b1100_0100_00_00);
    vecs[8]  = mk(3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 12'b0000_0000_00_00);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'b0000_1100_00_00);
    vecs[10] = mk(0, 0, 5, 0, 0, 0, 5, 0, 0, 0, 0, 12'b0000_0000_00_00);
    vecs[11] = mk(0, 0, 9, 9, 0, 9, 9, 1, 1, 0, 0, 12'b0000_0000_10_10);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rs1d = vecs[i].rs1d; rs2d = vecs[i].rs2d; rs1e = vecs[i].rs1e; rs2e = vecs[i].rs2e;
      rde = vecs[i].rde; rdm = vecs[i].rdm; rdw = vecs[i].rdw;
      rwm = vecs[i].rwm; rww = vecs[i].rww; loade = vecs[i].loade; pcsrc = vecs[i].pcsrc;
      #1;
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // Memory wait of three cycles, ready on the fourth.
    do_reset();
    memreq = 1; memready = 0;
    #1;
    check("mw_c0_outs", 32'(outs), 32'b1111_0001_0000);
    check("mw_c0_state", 32'(state), 0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("mw_c%0d_outs", c), 32'(outs), 32'b1111_0001_0000);
      check($sformatf("mw_c%0d_state", c), 32'(state), 1);
    end
    @(negedge clk);
    memready = 1;
    #1;
    check("mw_ready_outs", 32'(outs), 32'b0000_0000_0000);
    @(negedge clk);
    memreq = 0; memready = 0;
    #1;
    check("mw_end_state", 32'(state), 0);
    check("mw_end_cnt", 32'(stall_cnt), 3);

    // Ready/done in the same cycle as the request: no stall, no state change.
    @(negedge clk);
    memreq = 1; memready = 1; mdstart = 1; mddone = 1;
    #1;
    check("same_cycle_outs", 32'(outs), 32'b0000_0000_0000);
    @(negedge clk);
    memreq = 0; memready = 0; mdstart = 0; mddone = 0;
    #1;
    check("same_cycle_state", 32'(state), 0);
    check("same_cycle_cnt", 32'(stall_cnt), 3);

    // Timeout, twice without reset so the 5-bit stall counter saturates.
    do_reset();
    run_timeout(ns, nf);
    check("to1_stalls", 32'(ns), 16);
    check("to1_early_fault", 32'(nf), 0);
    check("to1_state_at_timeout", 32'(state), 1);
    @(negedge clk);
    #1;
    check("to1_state", 32'(state), 0);
    check("to1_fault", 32'(fault), 1);
    check("to1_cnt", 32'(stall_cnt), 16);
    @(negedge clk);
    #1;
    check("to1_fault_off", 32'(fault), 0);
    run_timeout(ns, nf);
    check("to2_stalls", 32'(ns), 16);
    @(negedge clk);
    #1;
    check("to2_fault", 32'(fault), 1);
    check("to2_cnt_sat", 32'(stall_cnt), 31);

    // Mul/div busy for five cycles with a taken branch held in E.
    do_reset();
    mdstart = 1; mddone = 0; pcsrc = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("md_c%0d_outs", c), 32'(outs), 32'b1110_0010_0000);
      check($sformatf("md_c%0d_state", c), 32'(state), (c == 0) ? 0 : 2);
      @(negedge clk);
    end
    mddone = 1; mdstart = 0;
    #1;
    check("md_done_outs", 32'(outs), 32'b0000_1100_0000);
    check("md_done_state", 32'(state), 2);
    @(negedge clk);
    mddone = 0; pcsrc = 0;
    #1;
    check("md_end_state", 32'(state), 0);
    check("md_end_cnt", 32'(stall_cnt), 5);

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    memreq = 1; memready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rm_pre_state", 32'(state), 1);
    #1;
    rst = 1'b1;
    memreq = 0;
    #1;
    check("rm_state", 32'(state), 0);
    check("rm_cnt", 32'(stall_cnt), 0);
    check("rm_outs", 32'(outs), 32'b0000_1111_0000);
    @(negedge clk);
    rst = 1'b0;
    nf = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (fault) nf++;
    end
    check("rm_no_fault", 32'(nf), 0);
    check("rm_post_state", 32'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It drives the stall and flush controls of the F/D, D/E, E/M and M/W pipeline registers, including the FlushE input of the D/E (execute) register. It also generates the Execute-stage forwarding selects. It sequences multi-cycle events through a small FSM: data-memory wait states, and a multi-cycle mul/div unit in E.

Parameters:
MEM_TIMEOUT, 16, max consecutive memory wait cycles before a fault is flagged (>=2)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Rs1D, i_Rs2D  in  5  source regs in Decode
i_Rs1E, i_Rs2E  in  5  source regs in Execute
i_RdE, i_RdM, i_RdW  in  5  dest regs in E/M/W
i_RegWriteM, i_RegWriteW  in  1  register write enables in M/W
i_LoadE  in  1  instruction in E is a load
i_PCSrcE  in  1  taken branch/jump resolved in E
i_MemReqM  in  1  load/store active in M
i_MemReadyM  in  1  data memory completes this cycle
i_MulDivStartE  in  1  multi-cycle op in E
i_MulDivDone  in  1  mul/div result valid this cycle
o_StallF, o_StallD, o_StallE, o_StallM  out  1  hold stage register
o_FlushD, o_FlushE, o_FlushM, o_FlushW  out  1  clear stage register (bubble)
o_ForwardAE, o_ForwardBE  out  2  00 reg file, 01 from W, 10 from M
o_MemFault  out  1  one-cycle pulse on memory timeout
o_State  out  2  00 RUN, 01 MEM_WAIT, 10 MD_BUSY
o_StallCount  out  CNT_W  cycles with o_StallF=1, saturating

Behaviour:
- Reset (async, while i_Reset=1): state RUN; wait counter 0; o_StallCount 0; o_MemFault 0. All stalls read 0, all flushes read 1, forwards read 00.
- Stall/flush/forward outputs are combinational from the current state and inputs (zero latency). o_MemFault and o_StallCount are registered.
- Forwarding (A shown; B identical with Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00.
  - M has priority over W.
- memWait = (state==RUN && MemReqM && !MemReadyM) || (state==MEM_WAIT && !MemReadyM && !timeout).
- mdWait = !memWait && ((state==RUN && MulDivStartE && !MulDivDone) || (state==MD_BUSY && !MulDivDone)).
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Priority, evaluated in this order:
  1. memWait: StallF/D/E/M=1, FlushW=1, all other flushes 0. A branch in E is held, not acted on.
  2. mdWait: StallF/D/E=1, FlushM=1. PCSrcE is ignored until the op completes.
  3. PCSrcE: FlushD=1, FlushE=1, no stalls. Overrides lwStall.
  4. lwStall: StallF=1, StallD=1, FlushE=1.
  5. Otherwise: all stalls and flushes 0.
- FSM transitions:
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM.
  - Else RUN -> MD_BUSY when MulDivStartE && !MulDivDone.
  - MEM_WAIT -> RUN when MemReadyM. The stall drops in that same cycle.
  - MEM_WAIT -> RUN on timeout, i.e. wait counter == MEM_TIMEOUT-1. o_MemFault pulses 1 in the next cycle; stall drops in the timeout cycle.
  - MD_BUSY -> RUN when MulDivDone. The stall drops in the done cycle.
- Wait counter:
  - Clears on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle.
  - Never wraps; the timeout exits first.
- o_StallCount: +1 each cycle o_StallF=1; holds at 2^CNT_W-1.
- Ready or done arriving in the same cycle as the request: no stall, no state change.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1; RdW=5, RegWriteW=1; Rs1E=5 -> ForwardAE=10. Set Rs2E=5 with RegWriteM=0 -> ForwardBE=01. RdM=0 -> 00.
- Load-use: LoadE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for 1 cycle. Same with PCSrcE=1 -> FlushD=FlushE=1 and StallF=0.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, state 01 then 00. o_StallCount=3.
- Timeout (MEM_TIMEOUT=16): MemReadyM never asserted -> state returns 00 after 16 stall cycles, o_MemFault=1 for exactly one cycle.
- Mul/div: MulDivStartE=1, MulDivDone after 5 cycles with PCSrcE=1 throughout -> StallF/D/E=1 and FlushM=1 for 5 cycles, no FlushD. After done, PCSrcE -> FlushD=FlushE=1.
- Reset mid-MEM_WAIT: assert i_Reset asynchronously -> state 00, o_StallCount 0, flushes 1 immediately, no o_MemFault pulse after release.
